// File: rtl/uart_alu_defs.sv
// Definitions shared by the UART-ALU link: byte width, one-hot FSM encoding
// and a constant-foldable clog2 used to size counters.
package uart_alu_defs;

    localparam int NB_DATA  = 8;
    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE      = 3'b001,
        ST_SEND      = 3'b010,
        ST_WAIT_DONE = 3'b100
    } state_t;

    // Never returns less than 1 so a single-entry counter still has a bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_tx_interface.sv
// Sends one ALU result to uart_tx as NB_DATA-wide bytes, LSB byte first,
// one start/done handshake per byte; results arriving while busy are dropped.
module uart_tx_interface #(
    parameter int NB_DATA   = uart_alu_defs::NB_DATA,
    parameter int NB_RESULT = 16
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic [NB_RESULT-1:0]                i_alu_result,
    input  logic                                i_alu_result_valid,
    input  logic                                i_tx_done,
    output logic [NB_DATA-1:0]                  o_tx_data,
    output logic                                o_tx_start,
    output logic                                o_busy,
    output logic                                o_overrun,
    output logic [uart_alu_defs::NB_STATE-1:0]  o_dbg_state
);
    import uart_alu_defs::*;

    localparam int N_BYTES = NB_RESULT / NB_DATA;
    localparam int CNT_W   = clog2(N_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

    if ((NB_RESULT % NB_DATA) != 0) begin : g_bad_width
        $fatal(1, "uart_tx_interface: NB_RESULT must be a multiple of NB_DATA");
    end

    // Handshake: o_tx_start pulses for one cycle with o_tx_data valid; the
    // byte is held until uart_tx answers with a one-cycle i_tx_done.
    state_t                 state_q, state_d;
    logic [NB_RESULT-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NB_DATA-1:0]     tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [NB_RESULT-1:0]   shift_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        shift_next = shift_q >> NB_DATA;

        case (state_q)
            ST_IDLE: begin
                if (i_alu_result_valid) begin
                    shift_d   = i_alu_result;
                    cnt_d     = '0;
                    tx_data_d = i_alu_result[NB_DATA-1:0];
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    if (cnt_q < LAST_CNT) begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        shift_d   = shift_next;
                        tx_data_d = shift_next[NB_DATA-1:0];
                        state_d   = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        tx_start_d = (state_d == ST_SEND);
        busy_d     = (state_d == ST_SEND) || (state_d == ST_WAIT_DONE);
        overrun_d  = i_alu_result_valid &&
                     ((state_q == ST_SEND) || (state_q == ST_WAIT_DONE));
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_q;
    assign o_overrun   = overrun_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_interface.sv
// Directed bench for uart_tx_interface: a byte scoreboard fed at strobe time
// and drained on every o_tx_start, plus a single-byte (NB_RESULT=8) instance.
module tb_uart_tx_interface;
    import uart_alu_defs::*;

    logic        i_clock;
    logic        i_reset;
    logic [15:0] i_alu_result;
    logic        i_alu_result_valid;
    logic        i_tx_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_overrun;
    logic [2:0]  o_dbg_state;

    logic [7:0]  r8_result;
    logic        r8_valid;
    logic        r8_done;
    logic [7:0]  r8_tx_data;
    logic        r8_tx_start;
    logic        r8_busy;
    logic        r8_overrun;
    logic [2:0]  r8_state;

    int          n_checks;
    int          n_errors;
    int          n_starts;
    int          n8_starts;
    logic [7:0]  exp_q[$];

    uart_tx_interface #(.NB_DATA(8), .NB_RESULT(16)) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_alu_result       (i_alu_result),
        .i_alu_result_valid (i_alu_result_valid),
        .i_tx_done          (i_tx_done),
        .o_tx_data          (o_tx_data),
        .o_tx_start         (o_tx_start),
        .o_busy             (o_busy),
        .o_overrun          (o_overrun),
        .o_dbg_state        (o_dbg_state)
    );

    uart_tx_interface #(.NB_DATA(8), .NB_RESULT(8)) dut8 (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_alu_result       (r8_result),
        .i_alu_result_valid (r8_valid),
        .i_tx_done          (r8_done),
        .o_tx_data          (r8_tx_data),
        .o_tx_start         (r8_tx_start),
        .o_busy             (r8_busy),
        .o_overrun          (r8_overrun),
        .o_dbg_state        (r8_state)
    );

    // Clock / reset
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic strobe(input logic [15:0] value);
        i_alu_result       = value;
        i_alu_result_valid = 1'b1;
        tick();
        i_alu_result_valid = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] value);
        exp_q.push_back(value[7:0]);
        exp_q.push_back(value[15:8]);
    endtask

    task automatic done_after(input int gap);
        repeat (gap) tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    // Scoreboard: every start must carry the next expected byte
    always @(negedge i_clock) begin
        if (!i_reset && o_tx_start) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                check("unexpected_start", {24'h0, o_tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("sb_byte", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (!i_reset && r8_tx_start) n8_starts++;
    end

    initial begin
        int s0;
        n_checks = 0; n_errors = 0; n_starts = 0; n8_starts = 0;
        i_reset = 1'b1; i_alu_result = '0; i_alu_result_valid = 1'b0; i_tx_done = 1'b0;
        r8_result = '0; r8_valid = 1'b0; r8_done = 1'b0;

        // Reset and idle
        tick(); tick();
        i_reset = 1'b0;
        check("rst_data", {24'h0, o_tx_data}, 32'h0);
        check("rst_start", {31'h0, o_tx_start}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_overrun", {31'h0, o_overrun}, 32'h0);
        check("rst_state", {29'h0, o_dbg_state}, {29'h0, ST_IDLE});
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_start", {31'h0, o_tx_start}, 32'h0);
        end
        check("idle_nstarts", n_starts, 0);

        // A55A with done 20 cycles after each start
        s0 = n_starts;
        push_word(16'hA55A);
        strobe(16'hA55A);
        check("a55a_start0", {31'h0, o_tx_start}, 32'h1);
        check("a55a_data0", {24'h0, o_tx_data}, 32'h5A);
        check("a55a_busy", {31'h0, o_busy}, 32'h1);
        tick();
        check("a55a_send_1cyc", {31'h0, o_tx_start}, 32'h0);
        check("a55a_hold0", {24'h0, o_tx_data}, 32'h5A);
        done_after(18);
        check("a55a_start1", {31'h0, o_tx_start}, 32'h1);
        check("a55a_data1", {24'h0, o_tx_data}, 32'hA5);
        done_after(19);
        check("a55a_busy_fall", {31'h0, o_busy}, 32'h0);
        check("a55a_no_start", {31'h0, o_tx_start}, 32'h0);
        tick();
        check("a55a_nstarts", n_starts - s0, 2);
        check("a55a_q_empty", exp_q.size(), 0);

        // Overrun during WAIT_DONE
        push_word(16'h1234);
        strobe(16'h1234);
        repeat (3) tick();
        strobe(16'hFFFF);
        check("ovr_pulse", {31'h0, o_overrun}, 32'h1);
        tick();
        check("ovr_single", {31'h0, o_overrun}, 32'h0);
        check("ovr_busy", {31'h0, o_busy}, 32'h1);
        done_after(2);
        check("ovr_data1", {24'h0, o_tx_data}, 32'h12);
        done_after(4);
        check("ovr_idle", {31'h0, o_busy}, 32'h0);
        repeat (3) tick();
        check("ovr_q_empty", exp_q.size(), 0);

        // Strobe coincident with final done is dropped; next cycle accepted
        push_word(16'h2211);
        strobe(16'h2211);
        done_after(3);
        repeat (3) tick();
        i_tx_done = 1'b1; i_alu_result = 16'h4433; i_alu_result_valid = 1'b1;
        tick();
        i_tx_done = 1'b0; i_alu_result_valid = 1'b0;
        check("coin_overrun", {31'h0, o_overrun}, 32'h1);
        check("coin_busy", {31'h0, o_busy}, 32'h0);
        check("coin_no_start", {31'h0, o_tx_start}, 32'h0);
        push_word(16'h6655);
        strobe(16'h6655);
        check("coin_accept", {31'h0, o_tx_start}, 32'h1);
        check("coin_data0", {24'h0, o_tx_data}, 32'h55);
        done_after(3);
        done_after(3);
        check("coin_idle", {31'h0, o_busy}, 32'h0);

        // Spurious done in IDLE and in SEND
        done_after(1);
        check("spur_idle_start", {31'h0, o_tx_start}, 32'h0);
        check("spur_idle_state", {29'h0, o_dbg_state}, {29'h0, ST_IDLE});
        push_word(16'h8877);
        strobe(16'h8877);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("spur_send_state", {29'h0, o_dbg_state}, {29'h0, ST_WAIT_DONE});
        check("spur_send_start", {31'h0, o_tx_start}, 32'h0);
        done_after(3);
        check("spur_data1", {24'h0, o_tx_data}, 32'h88);
        check("spur_busy1", {31'h0, o_busy}, 32'h1);
        done_after(3);
        check("spur_idle", {31'h0, o_busy}, 32'h0);

        // Reset mid-transfer aborts BEEF
        exp_q.push_back(8'hEF);
        strobe(16'hBEEF);
        repeat (3) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("abort_start", {31'h0, o_tx_start}, 32'h0);
        check("abort_busy", {31'h0, o_busy}, 32'h0);
        check("abort_data", {24'h0, o_tx_data}, 32'h0);
        tick();
        check("abort_start_after", {31'h0, o_tx_start}, 32'h0);
        push_word(16'h00C3);
        strobe(16'h00C3);
        check("abort_new_data0", {24'h0, o_tx_data}, 32'hC3);
        done_after(3);
        check("abort_new_data1", {24'h0, o_tx_data}, 32'h00);
        done_after(3);
        check("abort_idle", {31'h0, o_busy}, 32'h0);
        tick();
        check("abort_q_empty", exp_q.size(), 0);

        // Single-byte build
        s0 = n8_starts;
        r8_result = 8'h7E; r8_valid = 1'b1;
        tick();
        r8_valid = 1'b0;
        check("r8_start", {31'h0, r8_tx_start}, 32'h1);
        check("r8_data", {24'h0, r8_tx_data}, 32'h7E);
        repeat (4) tick();
        check("r8_busy", {31'h0, r8_busy}, 32'h1);
        r8_done = 1'b1;
        tick();
        r8_done = 1'b0;
        check("r8_busy_fall", {31'h0, r8_busy}, 32'h0);
        check("r8_hold", {24'h0, r8_tx_data}, 32'h7E);
        repeat (3) tick();
        check("r8_nstarts", n8_starts - s0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_interface.md
Name: uart_tx_interface

Overview:
Return path of the UART-ALU link. Captures one ALU result, splits it into NB_DATA-wide bytes, and sends them LSB-byte-first to the uart_tx serializer, one start/done handshake per byte. Sits between the ALU output and uart_tx, mirroring the receive-side operand/opcode collector. Results arriving while a transfer is in progress are dropped and flagged.

Parameters:
NB_DATA, 8, UART byte width
NB_RESULT, 16, ALU result width; must be an integer multiple of NB_DATA (elaboration-time check, fatal if not)
N_BYTES, NB_RESULT/NB_DATA, bytes per result (derived localparam, not overridable)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_alu_result  in  NB_RESULT  ALU result word
i_alu_result_valid  in  1  1-cycle strobe; i_alu_result is valid in this cycle only
i_tx_done  in  1  1-cycle pulse from uart_tx: current byte fully shifted out, including stop bit
o_tx_data  out  NB_DATA  byte to uart_tx; stable from o_tx_start until the matching i_tx_done
o_tx_start  out  1  1-cycle request to uart_tx to begin sending o_tx_data
o_busy  out  1  high while a result is being transmitted
o_overrun  out  1  1-cycle pulse: a result strobe was dropped

Behaviour:
- All outputs are registered.
- Reset (i_reset sampled high on a clock edge): state=IDLE, shift register=0, byte counter=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_overrun=0.
- Reset mid-transfer aborts immediately. The remaining bytes are discarded. No o_tx_start is issued in the reset cycle or the cycle after it.
- States (one-hot, 3 bits): IDLE, SEND, WAIT_DONE.
- IDLE:
  - On i_alu_result_valid: latch i_alu_result into the shift register, counter=0, go to SEND.
  - In the following cycle: o_tx_start=1, o_tx_data=result[NB_DATA-1:0], o_busy=1.
- SEND: lasts exactly one cycle (the o_tx_start cycle), then goes to WAIT_DONE. o_tx_start is low in every cycle except SEND.
- WAIT_DONE: hold o_tx_data. On i_tx_done:
  - If counter < N_BYTES-1: counter++, shift the register right by NB_DATA, go to SEND. The next byte appears with o_tx_start in the next cycle.
  - If counter == N_BYTES-1: go to IDLE. o_busy falls in the next cycle. o_tx_data keeps the last byte (don't care in IDLE).
- Latency: strobe at cycle N gives byte0 start at N+1. i_tx_done at cycle M gives the next start at M+1.
- i_tx_done is ignored in IDLE and SEND; it does not advance the counter.
- i_alu_result_valid in SEND or WAIT_DONE: result dropped, o_overrun=1 in the next cycle only, transfer unaffected.
  - This includes a strobe in the same cycle as the final i_tx_done. It is dropped because the state is not yet IDLE.
- N_BYTES=1 (NB_RESULT=NB_DATA): a single SEND/WAIT_DONE pass; the counter is effectively unused.
- Counter width: clog2(N_BYTES), minimum 1. It never exceeds N_BYTES-1.
- Undefined or illegal state encoding: go to IDLE, deassert o_tx_start and o_busy.

Decomposition:
- Shared package/include `uart_alu_defs`: NB_DATA, the state width, the one-hot state constants (IDLE=3'b001, SEND=3'b010, WAIT_DONE=3'b100), and a clog2 function. These are also used by the receive-side collector.
- Single module. No sub-module is needed; the shift register, counter and FSM fit comfortably.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, no o_tx_start.
- NB_RESULT=16, strobe with 16'hA55A; i_tx_done 20 cycles after each start:
  - Start at N+1 with 8'h5A.
  - Next start 1 cycle after the first done, with 8'hA5.
  - o_busy falls 1 cycle after the second done.
  - Exactly 2 starts in total.
- Strobe 16'h1234, then a second strobe 16'hFFFF during WAIT_DONE -> o_overrun single pulse; bytes sent are 8'h34, 8'h12 only.
- Strobe in the same cycle as the final i_tx_done -> dropped with o_overrun; a strobe one cycle later is accepted.
- Spurious i_tx_done in IDLE and in the SEND cycle -> no state change, no extra start, counter unchanged.
- Assert i_reset in WAIT_DONE of byte0 of 16'hBEEF, then strobe 16'h00C3 -> no 8'hBE is ever sent; the bytes sent are 8'hC3, 8'h00.
- NB_RESULT=8 build: strobe 8'h7E -> one start with 8'h7E; o_busy clears 1 cycle after done.
